// File: rtl/controlador_lavadora_param.sv
// Coin-operated washer controller: credit accumulation, service selection, change and timed run.
// All outputs registered (one-edge latency); no backpressure, coins during a service are rejected.
module controlador_lavadora_param #(
   parameter int CNT_W         = 5,
   parameter int PRECIO_SECADO = 3,
   parameter int PRECIO_LAVADO = 4,
   parameter int PRECIO_PESADO = 8,
   parameter int T_SECADO      = 6,
   parameter int T_LAVADO      = 10,
   parameter int T_PESADO      = 16,
   parameter int TMR_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             INTRO_MONEDAS,
   input  logic             FINALIZAR_PAGO,
   input  logic             CANCELAR,
   output logic             SECADO,
   output logic             LAVADO,
   output logic             LAVADO_PESADO,
   output logic             INSUFICIENTE,
   output logic             OCUPADO,
   output logic             RECHAZO,
   output logic [CNT_W-1:0] CREDITO,
   output logic [CNT_W-1:0] CAMBIO,
   output logic             CAMBIO_VALIDO,
   output logic [TMR_W-1:0] TIEMPO_RESTANTE
);

   typedef enum logic {PAGO, SERVICIO} estado_t;

   localparam logic [CNT_W-1:0] CRED_MAX = '1;
   localparam logic [CNT_W-1:0] P_SEC    = CNT_W'(PRECIO_SECADO);
   localparam logic [CNT_W-1:0] P_LAV    = CNT_W'(PRECIO_LAVADO);
   localparam logic [CNT_W-1:0] P_PES    = CNT_W'(PRECIO_PESADO);
   localparam logic [TMR_W-1:0] D_SEC    = TMR_W'(T_SECADO);
   localparam logic [TMR_W-1:0] D_LAV    = TMR_W'(T_LAVADO);
   localparam logic [TMR_W-1:0] D_PES    = TMR_W'(T_PESADO);

   estado_t          estado;
   logic             moneda_ok;
   logic [CNT_W-1:0] credito_c;
   logic             sel_ok;
   logic [2:0]       sel_svc;   // {pesado, lavado, secado}
   logic [CNT_W-1:0] sel_precio;
   logic [TMR_W-1:0] sel_tiempo;

   // Credit including this cycle's coin (saturated) and the best affordable service.
   always_comb begin
      moneda_ok  = INTRO_MONEDAS && (CREDITO != CRED_MAX);
      credito_c  = CREDITO + CNT_W'(moneda_ok);
      sel_ok     = 1'b1;
      sel_svc    = 3'b000;
      sel_precio = '0;
      sel_tiempo = '0;
      if (credito_c >= P_PES) begin
         sel_svc    = 3'b100;
         sel_precio = P_PES;
         sel_tiempo = D_PES;
      end else if (credito_c >= P_LAV) begin
         sel_svc    = 3'b010;
         sel_precio = P_LAV;
         sel_tiempo = D_LAV;
      end else if (credito_c >= P_SEC) begin
         sel_svc    = 3'b001;
         sel_precio = P_SEC;
         sel_tiempo = D_SEC;
      end else begin
         sel_ok     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado          <= PAGO;
         SECADO          <= 1'b0;
         LAVADO          <= 1'b0;
         LAVADO_PESADO   <= 1'b0;
         INSUFICIENTE    <= 1'b0;
         OCUPADO         <= 1'b0;
         RECHAZO         <= 1'b0;
         CREDITO         <= '0;
         CAMBIO          <= '0;
         CAMBIO_VALIDO   <= 1'b0;
         TIEMPO_RESTANTE <= '0;
      end else begin
         INSUFICIENTE  <= 1'b0;
         CAMBIO_VALIDO <= 1'b0;
         if (estado == PAGO) begin
            RECHAZO <= INTRO_MONEDAS && !moneda_ok;
            if (CANCELAR) begin
               CAMBIO        <= credito_c;
               CAMBIO_VALIDO <= 1'b1;
               CREDITO       <= '0;
            end else if (FINALIZAR_PAGO) begin
               if (sel_ok) begin
                  {LAVADO_PESADO, LAVADO, SECADO} <= sel_svc;
                  OCUPADO         <= 1'b1;
                  CAMBIO          <= credito_c - sel_precio;
                  CAMBIO_VALIDO   <= 1'b1;
                  CREDITO         <= '0;
                  TIEMPO_RESTANTE <= sel_tiempo;
                  estado          <= SERVICIO;
               end else begin
                  INSUFICIENTE <= 1'b1;
                  CREDITO      <= credito_c;
               end
            end else begin
               CREDITO <= credito_c;
            end
         end else begin
            RECHAZO <= INTRO_MONEDAS;
            // The remaining-time output doubles as the service timer.
            if (TIEMPO_RESTANTE == TMR_W'(1)) begin
               SECADO          <= 1'b0;
               LAVADO          <= 1'b0;
               LAVADO_PESADO   <= 1'b0;
               OCUPADO         <= 1'b0;
               TIEMPO_RESTANTE <= '0;
               estado          <= PAGO;
            end else begin
               TIEMPO_RESTANTE <= TIEMPO_RESTANTE - TMR_W'(1);
            end
         end
      end
   end

endmodule
